// File: rtl/pet_char_pixel_gen_pkg.sv
`default_nettype none
// =============================================================================
// Package    : pet_video_pkg
// Description: Shared constants, the sync/blank bundle type and the glyph-row
//              load function for the PET character video path.
// Revision   : 1.0 - initial release
// =============================================================================
package pet_video_pkg;

    localparam int PIPE_DEPTH = 2;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_ROWS = 8;
    localparam int ROW_W      = $clog2(GLYPH_ROWS);
    localparam int CODE_W     = 7;
    localparam int MA_W       = 10;
    localparam int RA_W       = 5;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
        logic de;
    } sync_bus_t;

    // A hidden character (border or blanked line) is black and is never inverted.
    function automatic logic [GLYPH_W-1:0] glyph_row(
        input logic [GLYPH_W-1:0] rom,
        input logic               inv,
        input logic               show
    );
        return show ? (rom ^ {GLYPH_W{inv}}) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pet_char_pixel_gen_if.sv
`default_nettype none
// =============================================================================
// Interface  : pet_char_pixel_gen_if
// Description: CRTC-compatible character video stream (source -> pixel gen).
// Revision   : 1.0 - initial release
// =============================================================================
interface pet_char_pixel_gen_if;

    logic                          vid_de;
    logic [pet_video_pkg::MA_W-1:0] vid_ma;
    logic [pet_video_pkg::RA_W-1:0] vid_ra;
    logic                          vid_hblank;
    logic                          vid_vblank;
    logic                          vid_hsync;
    logic                          vid_vsync;

    modport master (
        output vid_de, vid_ma, vid_ra, vid_hblank, vid_vblank, vid_hsync, vid_vsync
    );

    modport slave (
        input  vid_de, vid_ma, vid_ra, vid_hblank, vid_vblank, vid_hsync, vid_vsync
    );

endinterface
`default_nettype wire

// File: rtl/pet_char_pixel_gen_sync_delay.sv
`default_nettype none
// =============================================================================
// Module     : pet_sync_delay
// Description: ce-gated delay line for the sync/blank bundle; a value sampled
//              on tick t appears on q from tick t+DEPTH.
// Revision   : 1.0 - initial release
// =============================================================================
module pet_sync_delay
    import pet_video_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  wire       clk,
    input  wire       reset_n,
    input  wire       ce,
    input  sync_bus_t d,
    output sync_bus_t q
);

    sync_bus_t [DEPTH:0] r_stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else if (ce) begin
            r_stage <= {r_stage[DEPTH-1:0], d};
        end
    end

    assign q = r_stage[DEPTH];

endmodule
`default_nettype wire

// File: rtl/pet_char_pixel_gen.sv
`default_nettype none
// =============================================================================
// Module     : pet_char_pixel_gen
// Description: Screen-code fetch, char ROM lookup, reverse video and 8-pixel
//              shifter with matching sync/blank delay.
//              Option macro PET_SCREEN_INVERT_EN adds input invert_screen.
// Revision   : 1.0 - initial release
// =============================================================================
module pet_char_pixel_gen
    import pet_video_pkg::*;
#(
    parameter int VRAM_AW = 10,
    parameter int CROM_AW = 11
) (
    input  wire                  clk,
    input  wire                  reset_n,
    input  wire                  ce_1m,
    input  wire                  ce_8m,
    pet_char_pixel_gen_if.slave  vid,
    input  wire                  video_blank,
    input  wire                  video_gfx,
`ifdef PET_SCREEN_INVERT_EN
    input  wire                  invert_screen,
`endif
    output logic [VRAM_AW-1:0]   vram_addr,
    input  wire  [7:0]           vram_data,
    output logic [CROM_AW-1:0]   crom_addr,
    input  wire  [GLYPH_W-1:0]   crom_data,
    output logic                 pix,
    output logic                 pix_hblank,
    output logic                 pix_vblank,
    output logic                 pix_hsync,
    output logic                 pix_vsync,
    output logic                 pix_de
);

    logic [VRAM_AW-1:0] w_ma;
    logic [CROM_AW-1:0] w_crom_next;
    logic [GLYPH_W-1:0] w_load;
    logic               w_unused_ra;
    sync_bus_t          w_sync_in;
    sync_bus_t          w_sync_out;

    logic [ROW_W-1:0]   r_ra0;
    logic               r_de0;
    logic               r_de1;
    logic               r_inv1;
    logic [GLYPH_W-1:0] r_shreg;

    generate
        if (VRAM_AW <= MA_W) begin : g_ma_trunc
            assign w_ma = vid.vid_ma[VRAM_AW-1:0];
        end else begin : g_ma_ext
            assign w_ma = {{(VRAM_AW-MA_W){1'b0}}, vid.vid_ma};
        end
    endgenerate

    // Only eight glyph rows exist; the upper row-address bits are dropped.
    assign w_unused_ra = ^vid.vid_ra[RA_W-1:ROW_W];

    assign w_crom_next = {video_gfx, vram_data[CODE_W-1:0], r_ra0};

    // S0 issues the RAM read, S1 the ROM read; both hold between ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr <= '0;
            r_ra0     <= '0;
            r_de0     <= 1'b0;
            crom_addr <= '0;
            r_inv1    <= 1'b0;
            r_de1     <= 1'b0;
        end else if (ce_1m) begin
            vram_addr <= w_ma;
            r_ra0     <= vid.vid_ra[ROW_W-1:0];
            r_de0     <= vid.vid_de;
            crom_addr <= w_crom_next;
            r_inv1    <= vram_data[7];
            r_de1     <= r_de0;
        end
    end

`ifdef PET_SCREEN_INVERT_EN
    assign w_load = glyph_row(crom_data, r_inv1, r_de1 && !video_blank)
                  ^ {GLYPH_W{invert_screen}};
`else
    assign w_load = glyph_row(crom_data, r_inv1, r_de1 && !video_blank);
`endif

    // A character-boundary load takes priority over the coincident shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg <= '0;
        end else if (ce_1m) begin
            r_shreg <= w_load;
        end else if (ce_8m) begin
            r_shreg <= {r_shreg[GLYPH_W-2:0], 1'b0};
        end
    end

    assign pix = r_shreg[GLYPH_W-1];

    assign w_sync_in = '{hblank: vid.vid_hblank,
                         vblank: vid.vid_vblank,
                         hsync:  vid.vid_hsync,
                         vsync:  vid.vid_vsync,
                         de:     vid.vid_de};

    pet_sync_delay #(
        .DEPTH (PIPE_DEPTH)
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce_1m),
        .d       (w_sync_in),
        .q       (w_sync_out)
    );

    assign pix_hblank = w_sync_out.hblank;
    assign pix_vblank = w_sync_out.vblank;
    assign pix_hsync  = w_sync_out.hsync;
    assign pix_vsync  = w_sync_out.vsync;
    assign pix_de     = w_sync_out.de;

endmodule
`default_nettype wire

// File: tb/tb_pet_char_pixel_gen.sv
`default_nettype none
// =============================================================================
// Module     : tb_pet_char_pixel_gen
// Description: Scoreboard bench: characters are queued with their expected
//              pixel byte and sync bundle, checked when their load tick arrives.
// Revision   : 1.0 - initial release
// =============================================================================
module tb_pet_char_pixel_gen;
    import pet_video_pkg::*;

    typedef struct {
        int         tick;
        logic [7:0] pix;
        logic [4:0] sync;
    } exp_t;

    typedef struct {
        logic [9:0] ma;
        logic [4:0] ra;
        logic       de, gfx, blank, hb, vb, hs, vs;
    } chr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_1m = 1'b0;
    logic        ce_8m = 1'b0;
    logic        video_blank = 1'b0;
    logic        video_gfx = 1'b0;
`ifdef PET_SCREEN_INVERT_EN
    logic        invert_screen = 1'b0;
`endif
    logic [9:0]  vram_addr;
    logic [7:0]  vram_data = 8'h00;
    logic [10:0] crom_addr;
    logic [7:0]  crom_data = 8'h00;
    logic        pix, pix_hblank, pix_vblank, pix_hsync, pix_vsync, pix_de;

    logic [7:0]  vram [0:1023];
    logic [7:0]  crom [0:2047];

    int          n_checks = 0;
    int          n_pass = 0;
    int          tick_no = 0;
    logic [3:0]  ph = 4'd0;
    event        ev_pre_tick;
    exp_t        sb[$];
    chr_t        prev1, prev2, idle;

    pet_char_pixel_gen_if vid_if();

    pet_char_pixel_gen #(
        .VRAM_AW (10),
        .CROM_AW (11)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce_1m         (ce_1m),
        .ce_8m         (ce_8m),
        .vid           (vid_if),
        .video_blank   (video_blank),
        .video_gfx     (video_gfx),
`ifdef PET_SCREEN_INVERT_EN
        .invert_screen (invert_screen),
`endif
        .vram_addr     (vram_addr),
        .vram_data     (vram_data),
        .crom_addr     (crom_addr),
        .crom_data     (crom_data),
        .pix           (pix),
        .pix_hblank    (pix_hblank),
        .pix_vblank    (pix_vblank),
        .pix_hsync     (pix_hsync),
        .pix_vsync     (pix_vsync),
        .pix_de        (pix_de)
    );

    initial forever #5 clk = ~clk;

    // Synchronous RAM/ROM models: data one clk after the address.
    always @(posedge clk) vram_data <= vram[vram_addr];
    always @(posedge clk) crom_data <= crom[crom_addr];

    // 16 clk per character, ce_8m every 2nd clk, coinciding with ce_1m.
    initial begin : ce_gen
        forever begin
            @(posedge clk);
            #2;
            ph    = ph + 4'd1;
            ce_8m = (ph[0] == 1'b0);
            ce_1m = (ph == 4'd0);
            if (ph == 4'd0) begin
                tick_no = tick_no + 1;
                -> ev_pre_tick;
            end
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [7:0] got;
        logic [4:0] gs;
        forever begin
            @(posedge clk);
            if (ce_1m && reset_n && sb.size() > 0 && sb[0].tick < tick_no) begin
                n_checks++;
                $display("FAIL sb_missed tick=%0d got=none expected_tick=%0d", tick_no, sb[0].tick);
                void'(sb.pop_front());
            end
            if (ce_1m && reset_n && sb.size() > 0 && sb[0].tick == tick_no) begin
                e = sb.pop_front();
                #1;
                got[7] = pix;
                gs = {pix_hblank, pix_vblank, pix_hsync, pix_vsync, pix_de};
                for (int i = 6; i >= 0; i--) begin
                    do @(posedge clk); while (!(ce_8m && !ce_1m));
                    #1;
                    got[i] = pix;
                end
                n_checks++;
                if (got !== e.pix)
                    $display("FAIL pix_byte tick=%0d got=%h expected=%h", e.tick, got, e.pix);
                else
                    n_pass++;
                n_checks++;
                if (gs !== e.sync)
                    $display("FAIL sync_align tick=%0d got=%b expected=%b", e.tick, gs, e.sync);
                else
                    n_pass++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    function automatic chr_t mk(input logic [9:0] ma, input logic [4:0] ra,
                                input logic de, input logic gfx, input logic blank);
        chr_t c;
        c.ma = ma; c.ra = ra; c.de = de; c.gfx = gfx; c.blank = blank;
        c.hb = 1'b0; c.vb = 1'b0; c.hs = 1'b0; c.vs = 1'b0;
        return c;
    endfunction

    // Presents one character on the next tick; gfx/blank of older characters
    // are driven at their S1/S2 ticks.
    task automatic present(input chr_t c, input bit push);
        logic [7:0] code, g;
        exp_t       e;
        @(ev_pre_tick);
        vid_if.vid_ma     = c.ma;
        vid_if.vid_ra     = c.ra;
        vid_if.vid_de     = c.de;
        vid_if.vid_hblank = c.hb;
        vid_if.vid_vblank = c.vb;
        vid_if.vid_hsync  = c.hs;
        vid_if.vid_vsync  = c.vs;
        video_gfx         = prev1.gfx;
        video_blank       = prev2.blank;
        if (push) begin
            code   = vram[c.ma];
            g      = crom[{c.gfx, code[6:0], c.ra[2:0]}];
            e.tick = tick_no + 2;
            e.pix  = (c.de && !c.blank) ? (code[7] ? ~g : g) : 8'h00;
            e.sync = {c.hb, c.vb, c.hs, c.vs, c.de};
            sb.push_back(e);
        end
        prev2 = prev1;
        prev1 = c;
    endtask

    task automatic test_reset();
        vid_if.vid_ma = 10'h155; vid_if.vid_ra = 5'h1F; vid_if.vid_de = 1'b1;
        vid_if.vid_hblank = 1'b1; vid_if.vid_vblank = 1'b1;
        vid_if.vid_hsync = 1'b1; vid_if.vid_vsync = 1'b1;
        video_gfx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if (pix !== 1'b0) $display("FAIL rst_pix got=%b expected=0", pix); else n_pass++;
        n_checks++;
        if ({pix_hblank, pix_vblank, pix_hsync, pix_vsync, pix_de} !== 5'b0)
            $display("FAIL rst_sync got=%b expected=00000", {pix_hblank, pix_vblank, pix_hsync, pix_vsync, pix_de});
        else n_pass++;
        n_checks++; if (vram_addr !== 10'h0) $display("FAIL rst_vram_addr got=%h expected=000", vram_addr); else n_pass++;
        n_checks++; if (crom_addr !== 11'h0) $display("FAIL rst_crom_addr got=%h expected=000", crom_addr); else n_pass++;
        reset_n = 1'b1;
        @(ev_pre_tick);
        n_checks++; if (vram_addr !== 10'h0) $display("FAIL rel_vram_addr got=%h expected=000", vram_addr); else n_pass++;
        n_checks++; if (pix_hsync !== 1'b0) $display("FAIL rel_hsync got=%b expected=0", pix_hsync); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (vram_addr !== 10'h155) $display("FAIL first_vram_addr got=%h expected=155", vram_addr); else n_pass++;
        n_checks++; if (pix_de !== 1'b0) $display("FAIL first_pix_de got=%b expected=0", pix_de); else n_pass++;
    endtask

    task automatic test_async_reset();
        present(mk(10'd5, 5'd3, 1'b1, 1'b0, 1'b0), 1'b0);
        present(idle, 1'b0);
        present(idle, 1'b0);
        @(posedge clk); #1;
        n_checks++; if (pix !== 1'b1) $display("FAIL pre_areset_pix got=%b expected=1", pix); else n_pass++;
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (pix !== 1'b0) $display("FAIL areset_pix got=%b expected=0", pix); else n_pass++;
        n_checks++; if (pix_de !== 1'b0) $display("FAIL areset_pix_de got=%b expected=0", pix_de); else n_pass++;
        n_checks++; if (vram_addr !== 10'h0) $display("FAIL areset_vram_addr got=%h expected=000", vram_addr); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        prev1 = idle;
        prev2 = idle;
    endtask

    task automatic test_basic_glyph();
        present(mk(10'd5, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
        @(posedge clk); #1;
        n_checks++; if (vram_addr !== 10'd5) $display("FAIL basic_vram_addr got=%h expected=005", vram_addr); else n_pass++;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (vram_addr !== 10'd5) $display("FAIL vram_addr_hold got=%h expected=005", vram_addr); else n_pass++;
        present(idle, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (crom_addr !== 11'h00B) $display("FAIL basic_crom_addr got=%h expected=00b", crom_addr); else n_pass++;
        present(idle, 1'b1);
        present(idle, 1'b1);
    endtask

    task automatic test_reverse();
        present(mk(10'd6, 5'd27, 1'b1, 1'b0, 1'b0), 1'b1);
        present(idle, 1'b1);
        present(idle, 1'b1);
    endtask

    task automatic test_gating();
        present(mk(10'd6, 5'd3, 1'b0, 1'b0, 1'b0), 1'b1);
        present(mk(10'd7, 5'd3, 1'b1, 1'b0, 1'b1), 1'b1);
        present(mk(10'd7, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
        present(idle, 1'b1);
        present(idle, 1'b1);
    endtask

    task automatic test_charset();
        logic [10:0] ea, eb, ec;
        ea = {1'b0, vram[20][6:0], 3'd1};
        eb = {1'b1, vram[21][6:0], 3'd2};
        ec = {1'b0, vram[22][6:0], 3'd7};
        present(mk(10'd20, 5'd1, 1'b1, 1'b0, 1'b0), 1'b1);
        present(mk(10'd21, 5'd2, 1'b1, 1'b1, 1'b0), 1'b1);
        @(posedge clk); #1;
        n_checks++; if (crom_addr !== ea) $display("FAIL gfx_a_crom got=%h expected=%h", crom_addr, ea); else n_pass++;
        #20 video_gfx = ~video_gfx;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (crom_addr !== ea) $display("FAIL gfx_midchar_crom got=%h expected=%h", crom_addr, ea); else n_pass++;
        present(mk(10'd22, 5'd7, 1'b1, 1'b0, 1'b0), 1'b1);
        @(posedge clk); #1;
        n_checks++; if (crom_addr !== eb) $display("FAIL gfx_b_crom got=%h expected=%h", crom_addr, eb); else n_pass++;
        present(idle, 1'b1);
        @(posedge clk); #1;
        n_checks++; if (crom_addr !== ec) $display("FAIL gfx_c_crom got=%h expected=%h", crom_addr, ec); else n_pass++;
        present(idle, 1'b1);
    endtask

    task automatic test_alignment();
        chr_t c;
        for (int k = 0; k < 10; k++) begin
            c = mk(10'($urandom), 5'($urandom), (k >= 1 && k <= 7), 1'($urandom), 1'b0);
            c.hb = (k == 0 || k == 9);
            c.hs = (k >= 2 && k <= 5);
            c.vb = (k >= 3 && k <= 4);
            c.vs = (k >= 4 && k <= 7);
            present(c, 1'b1);
        end
        present(idle, 1'b1);
        present(idle, 1'b1);
    endtask

    task automatic test_back_to_back();
        present(mk(10'd5, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
        present(mk(10'd6, 5'd3, 1'b1, 1'b0, 1'b0), 1'b1);
        for (int k = 0; k < 12; k++) begin
            present(mk(10'($urandom), 5'($urandom), ($urandom_range(0, 3) != 0),
                       1'($urandom), ($urandom_range(0, 7) == 0)), 1'b1);
        end
        present(idle, 1'b1);
        present(idle, 1'b1);
        present(idle, 1'b1);
    endtask

    initial begin : main
        vid_if.vid_ma = '0; vid_if.vid_ra = '0; vid_if.vid_de = 1'b0;
        vid_if.vid_hblank = 1'b0; vid_if.vid_vblank = 1'b0;
        vid_if.vid_hsync = 1'b0; vid_if.vid_vsync = 1'b0;
        idle  = mk(10'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        prev1 = idle;
        prev2 = idle;
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
        vram[5] = 8'h01;
        vram[6] = 8'h81;
        vram[7] = 8'h02;
        crom[11'h00B] = 8'hA5;
        crom[11'h013] = 8'hFF;

        test_reset();
        test_async_reset();
        test_basic_glyph();
        test_reverse();
        test_gating();
        test_charset();
        test_alignment();
        test_back_to_back();

        repeat (3) @(ev_pre_tick);
        @(posedge clk); #1;
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drain got=%0d expected=0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pet_char_pixel_gen.md
Name: pet_char_pixel_gen

Overview:
- Consumer end of the CRTC-compatible character video interface: vid_de, vid_ma, vid_ra, vid_hblank, vid_vblank, vid_hsync, vid_vsync.
- Takes that stream from the discrete PET timing generator (or the CRTC, via the existing video/crtc multiplexer).
- Per character:
  - fetches the screen code from video RAM;
  - looks up the glyph row in character ROM;
  - applies reverse video;
  - shifts out 8 pixels at 8 MHz with sync/blank delayed to match.
- Sits between the video/crtc multiplexer and the scan converter / video output.

Parameters:
- VRAM_AW, 10, video RAM address width; vid_ma is truncated or zero-extended to this width.
- CROM_AW, 11, char ROM address width; must equal 1 + 7 + 3.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ce_1m, in, 1, character-rate enable, one clk pulse per character.
- ce_8m, in, 1, pixel-rate enable, 8 pulses per ce_1m period; one pulse coincides with each ce_1m.
- vid_de, in, 1, display-enable from the timing source.
- vid_ma, in, 10, character matrix address.
- vid_ra, in, 5, row address within the character; only bits [2:0] are used.
- vid_hblank, in, 1, horizontal blank.
- vid_vblank, in, 1, vertical blank.
- vid_hsync, in, 1, horizontal sync.
- vid_vsync, in, 1, vertical sync.
- video_blank, in, 1, forces black pixels (PIA blank line).
- video_gfx, in, 1, selects the character set: 0 = upper/graphics, 1 = lower/upper.
- vram_addr, out, VRAM_AW, video RAM read address.
- vram_data, in, 8, synchronous RAM read data; valid one clk after vram_addr changes.
- crom_addr, out, CROM_AW, character ROM address = {gfx, code[6:0], ra[2:0]}.
- crom_data, in, 8, synchronous ROM data; valid one clk after crom_addr changes.
- pix, out, 1, pixel output, 1 = lit.
- pix_hblank, out, 1, delayed hblank.
- pix_vblank, out, 1, delayed vblank.
- pix_hsync, out, 1, delayed hsync.
- pix_vsync, out, 1, delayed vsync.
- pix_de, out, 1, delayed display-enable.

Behaviour:
- Reset: all outputs and all internal registers are 0, and stay 0 until the first ce_1m after reset_n deasserts. Reset is effective mid-line: the pipeline is flushed and there is no partial character.
- Pipeline: three stages, each advancing only on ce_1m. Character k presented at ce_1m tick t.
  - S0 (tick t): vram_addr <= vid_ma[VRAM_AW-1:0]; ra0 <= vid_ra[2:0]; de0 <= vid_de. Sync/blank inputs enter the delay line.
  - S1 (tick t+1): code <= vram_data.
    - crom_addr <= {video_gfx, vram_data[6:0], ra0}.
    - inv1 <= vram_data[7].
    - de1 <= de0.
  - S2 (tick t+2): shreg <= (de1 && !video_blank) ? (crom_data ^ {8{inv1}}) : 8'h00. Outputs pix_de <= de1 and the sync/blank signals delayed by 2 ticks.
- Pixel shift:
  - pix = shreg[7]; MSB first. Pixel 0 is visible from the S2 load tick.
  - On every ce_8m without ce_1m: shreg <= {shreg[6:0], 1'b0}.
  - When ce_1m and ce_8m coincide, the load wins.
  - If no further load occurs, the 9th and later pixels are 0.
- Total latency from vid_ma presented to the first pixel is exactly 2 ce_1m periods. This matches video_on falling 2 characters after the last fetch.
- Disabled characters:
  - vid_de = 0 still issues a RAM read (address don't-care), but the pixels are black and inversion is suppressed.
  - Blank is never inverted.
- Signal sampling points:
  - video_gfx is sampled at S1.
  - video_blank is sampled at S2.
  - A mid-character change takes effect on the next character boundary only.
- Input and output widths:
  - vid_ra[4:3] are ignored.
  - vid_ma values at or above 1000 are passed through unchanged (RAM wraps by width).
- Between ce_1m pulses, vram_addr and crom_addr hold stable.
- ce_8m with ce_1m low for more than 8 pulses is not supported; the behaviour is the shifting defined above.

Optional Feature:
- Macro PET_SCREEN_INVERT_EN.
- Defined: extra input invert_screen (1 bit), sampled at S2. When 1, the loaded shreg value is additionally XORed with 8'hFF, including on de/blank-gated loads, so the border and blank show lit.
- Undefined: no port; behaviour exactly as above.

Decomposition:
- Package pet_video_pkg:
  - PIPE_DEPTH = 2 (ce_1m ticks);
  - GLYPH_W = 8;
  - GLYPH_ROWS = 8;
  - typedef sync_bus_t, a struct of hblank/vblank/hsync/vsync/de.
- One sub-module, pet_sync_delay: a PIPE_DEPTH-stage ce-gated delay line for sync_bus_t, reusable by the CRTC path.

Test Plan:
- Reset: hold reset_n = 0, toggle ce_1m/ce_8m → pix = 0, all pix_* = 0, vram_addr = 0. Assert reset_n = 0 mid-shift → pix goes 0 immediately (async).
- Basic glyph: vid_ma = 5, vid_ra = 3, de = 1, vram_data = 8'h01, gfx = 0, crom_data = 8'hA5.
  - crom_addr = 11'h00B one tick later.
  - The next tick pix emits 1,0,1,0,0,1,0,1 on successive ce_8m.
- Reverse video: vram_data = 8'h81, same ROM data → pix sequence 0,1,0,1,1,0,1,0.
- Gating:
  - de = 0 with vram_data = 8'h81 → 8 zero pixels.
  - video_blank = 1 at S2 with de = 1, crom_data = 8'hFF → 8 zero pixels.
- Alignment: pulse vid_hsync high for 4 ticks starting at tick 50 → pix_hsync high for ticks 52–55 exactly. The same applies for vblank/vsync/de.
- Charset switch: toggle video_gfx between characters → crom_addr[10] follows at each S1 only. Back-to-back characters produce a continuous 16-pixel stream with no gap.
